// File: rtl/weight_loader.sv
// Packs a column-major element stream into NROW-wide column words and writes
// them to weightRAM at successive column addresses, holding dot_prod in reset.
//
// state | meaning
// IDLE  | waiting for start; all outputs low
// FILL  | accepting elements into the packed column register
// WRITE | one-cycle weightRAM write of the completed column
// DONE  | one-cycle loadDone pulse, then back to IDLE
module weight_loader #(
  parameter int NROW          = 32,
  parameter int NCOL          = 4,
  parameter int BITWIDTH      = 18,
  parameter int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [BITWIDTH-1:0]      inData,
  output logic                     writeEn,
  output logic [ADDR_BITWIDTH-1:0] colAddressWrite,
  output logic [NROW*BITWIDTH-1:0] weightMemInput,
  output logic                     dotReset,
  output logic                     busy,
  output logic                     loadDone
);

  localparam int RW = (NROW > 1) ? $clog2(NROW) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [RW-1:0]            row_cnt_q, row_cnt_d;
  logic [ADDR_BITWIDTH-1:0] col_cnt_q, col_cnt_d;
  logic [NROW*BITWIDTH-1:0] pack_q, pack_d;
  logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [NROW*BITWIDTH-1:0] word_q, word_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      pack_q    <= '0;
      addr_q    <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      pack_q    <= pack_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    pack_d    = pack_q;
    addr_d    = addr_q;
    word_d    = word_q;
    inReady   = 1'b0;
    writeEn   = 1'b0;
    dotReset  = 1'b0;
    busy      = 1'b1;
    loadDone  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = FILL;
          row_cnt_d = '0;
          col_cnt_d = '0;
        end
      end
      FILL: begin
        inReady  = 1'b1;
        dotReset = 1'b1;
        if (inValid) begin
          pack_d[row_cnt_q*BITWIDTH +: BITWIDTH] = inData;
          if (row_cnt_q == RW'(NROW - 1)) begin
            row_cnt_d = '0;
            state_d   = WRITE;
            // Capture address and word so they stay stable through the write.
            addr_d    = col_cnt_q;
            word_d    = pack_d;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        writeEn  = 1'b1;
        dotReset = 1'b1;
        if (col_cnt_q == ADDR_BITWIDTH'(NCOL - 1)) begin
          state_d = DONE;
        end else begin
          col_cnt_d = col_cnt_q + 1'b1;
          state_d   = FILL;
        end
      end
      DONE: begin
        loadDone = 1'b1;
        dotReset = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign colAddressWrite = addr_q;
  assign weightMemInput  = word_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: default 32x4 build plus a 4x3 build,
// checking write addresses, packed words, cycle timing and dotReset window.
module tb_weight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, startA, vA, rdyA, weA, drA, busyA, ldA;
  logic [17:0]  dA;
  logic [1:0]   addrA;
  logic [575:0] memA;

  logic rstB, startB, vB, rdyB, weB, drB, busyB, ldB;
  logic [17:0]  dB;
  logic [1:0]   addrB;
  logic [71:0]  memB;

  weight_loader u_dut_a (
    .clock(clk), .reset(rstA), .start(startA), .inValid(vA), .inReady(rdyA),
    .inData(dA), .writeEn(weA), .colAddressWrite(addrA), .weightMemInput(memA),
    .dotReset(drA), .busy(busyA), .loadDone(ldA)
  );

  weight_loader #(.NROW(4), .NCOL(3), .BITWIDTH(18)) u_dut_b (
    .clock(clk), .reset(rstB), .start(startB), .inValid(vB), .inReady(rdyB),
    .inData(dB), .writeEn(weB), .colAddressWrite(addrB), .weightMemInput(memB),
    .dotReset(drB), .busy(busyB), .loadDone(ldB)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur = 0;
  int w_addr[$];
  int w_cyc[$];
  logic [575:0] w_data[$];
  int ld_cnt, ld_cyc, dr_first, dr_last, dr_cnt, bad_rdy, stalls;

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic v, input logic [17:0] d);
    if (cur == 0) begin
      rstA = rst; startA = st; vA = v; dA = d;
    end else begin
      rstB = rst; startB = st; vB = v; dB = d;
    end
  endtask

  function automatic logic [575:0] exp_word(input int k, input int nrow);
    logic [575:0] w;
    w = '0;
    for (int l = 0; l < nrow; l++) w[l*18 +: 18] = 18'(k*nrow + l);
    return w;
  endfunction

  task automatic clear_log();
    w_addr.delete(); w_cyc.delete(); w_data.delete();
    ld_cnt = 0; ld_cyc = -1; dr_first = -1; dr_last = -1; dr_cnt = 0;
    bad_rdy = 0; stalls = 0;
  endtask

  // Advance one clock and log the selected DUT's outputs 1 ns after the edge.
  task automatic step();
    logic we, rdy, dr, ld;
    logic [1:0] ad;
    logic [575:0] md;
    @(posedge clk);
    #1;
    cyc++;
    we  = (cur == 0) ? weA  : weB;
    rdy = (cur == 0) ? rdyA : rdyB;
    dr  = (cur == 0) ? drA  : drB;
    ld  = (cur == 0) ? ldA  : ldB;
    ad  = (cur == 0) ? addrA : addrB;
    md  = (cur == 0) ? memA : {504'b0, memB};
    if (we) begin
      w_addr.push_back(int'(ad));
      w_data.push_back(md);
      w_cyc.push_back(cyc);
    end
    if (we && rdy) bad_rdy++;
    if (ld) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
    if (dr) begin
      if (dr_first < 0) dr_first = cyc;
      dr_last = cyc;
      dr_cnt++;
    end
  endtask

  // Start a load in the current cycle and stream elements 0,1,2,... until loadDone.
  task automatic run(input int stall, input bit glitch, input bit bogus, input int abort_n,
                     output int c0);
    int idx, n;
    logic rdy, v;
    logic [17:0] d;
    idx = 0;
    n = 0;
    clear_log();
    c0 = cyc;
    drive(1'b0, 1'b1, 1'b0, 18'h0);
    step();
    while (ld_cnt == 0 && n < 400) begin
      rdy = (cur == 0) ? rdyA : rdyB;
      if (abort_n > 0 && idx == abort_n) begin
        drive(1'b1, 1'b0, 1'b0, 18'h0);
        step();
        break;
      end
      v = 1'b1;
      d = 18'(idx);
      if (stall > 0 && (n % 3) == 2) v = 1'b0;
      if (!rdy && bogus) begin
        v = 1'b1;
        d = 18'h3ffff;
      end
      if (rdy && !v) stalls++;
      drive(1'b0, glitch && idx == 70, v, d);
      if (v && rdy) idx++;
      step();
      n++;
    end
    drive(1'b0, 1'b0, 1'b0, 18'h0);
  endtask

  task automatic check_load(input string tag, input int c0, input int ncol, input int nrow);
    chk({tag, "_nwrites"}, 576'(w_addr.size()), 576'(ncol));
    for (int k = 0; k < ncol && k < w_addr.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 576'(w_addr[k]), 576'(k));
      chk($sformatf("%s_data%0d", tag, k), w_data[k], exp_word(k, nrow));
    end
    if (stalls == 0 && w_cyc.size() > 0)
      chk({tag, "_first_we"}, 576'(w_cyc[0] - c0), 576'(nrow + 1));
    chk({tag, "_done_cnt"}, 576'(ld_cnt), 576'(1));
    chk({tag, "_done_cyc"}, 576'(ld_cyc - c0), 576'(ncol*(nrow + 1) + 1 + stalls));
    chk({tag, "_dr_first"}, 576'(dr_first - c0), 576'(1));
    chk({tag, "_dr_last"}, 576'(dr_last - c0), 576'(ncol*(nrow + 1) + 1 + stalls));
    chk({tag, "_dr_solid"}, 576'(dr_cnt), 576'(dr_last - dr_first + 1));
    chk({tag, "_rdy_in_we"}, 576'(bad_rdy), 576'(0));
  endtask

  initial begin
    int c0;
    rstA = 1'b1; startA = 1'b1; vA = 1'b1; dA = 18'h3ffff;
    rstB = 1'b1; startB = 1'b0; vB = 1'b0; dB = 18'h0;
    clear_log();
    step();
    step();
    // start together with reset must not begin a load
    chk("rst_ctl", 576'({rdyA, weA, drA, busyA, ldA}), 576'(0));
    chk("rst_addr", 576'(addrA), 576'(0));
    chk("rst_mem", memA, 576'(0));
    rstA = 1'b0; startA = 1'b0; vA = 1'b0; dA = 18'h0; rstB = 1'b0;
    step();
    chk("idle_ctl", 576'({rdyA, weA, drA, busyA, ldA}), 576'(0));

    run(0, 1'b0, 1'b0, 0, c0);
    check_load("gapless", c0, 4, 32);
    step(); step();

    run(1, 1'b0, 1'b0, 0, c0);
    check_load("stall", c0, 4, 32);
    step(); step();

    run(0, 1'b1, 1'b1, 0, c0);
    check_load("restart_bogus", c0, 4, 32);
    step(); step();

    run(0, 1'b0, 1'b0, 40, c0);
    chk("abort_nwrites", 576'(w_addr.size()), 576'(1));
    if (w_addr.size() > 0) begin
      chk("abort_addr0", 576'(w_addr[0]), 576'(0));
      chk("abort_data0", w_data[0], exp_word(0, 32));
    end
    chk("abort_ctl", 576'({rdyA, weA, drA, busyA, ldA}), 576'(0));
    chk("abort_addr", 576'(addrA), 576'(0));
    chk("abort_mem", memA, 576'(0));
    chk("abort_done", 576'(ld_cnt), 576'(0));
    step();

    run(0, 1'b0, 1'b0, 0, c0);
    check_load("reload", c0, 4, 32);
    step();
    chk("gap_ctl", 576'({drA, busyA, ldA}), 576'(0));
    run(0, 1'b0, 1'b0, 0, c0);
    check_load("b2b", c0, 4, 32);
    step(); step();

    cur = 1;
    step();
    run(0, 1'b0, 1'b0, 0, c0);
    check_load("small", c0, 3, 4);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
